pcs_am_insert: RTL and testbench

//  Parametrised multi-lane 40GBASE-R alignment marker (AM) inserter.
//  - Sits after the per-lane scrambler and before the PMA gearbox.
//  - Passes scrambled 66b blocks through on LANE_N lanes.
//  - Every AM_PERIOD accepted blocks, stalls the MAC side for one cycle and emits one AM per lane.
//  - Optionally carries BIP3/BIP7 parity over each lane's stream.

---
 rtl/pcs_am_insert.sv | 74 +++++++
 tb/tb_pcs_am_insert.sv | 119 +++++++++++
 2 files changed

// File: rtl/pcs_am_insert.sv
// pcs_am_insert: multi-lane 40GBASE-R alignment marker inserter with one-cycle MAC stall per marker.
// Define PCS_AM_BIP_EN to carry BIP3/BIP7 lane parity; otherwise markers carry BIP3=00/BIP7=FF.
module pcs_am_insert #(
    parameter int LANE_N    = 4,
    parameter int DATA_W    = 64,
    parameter int HEAD_W    = 2,
    parameter int AM_PERIOD = 16383
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [LANE_N*HEAD_W-1:0]   head_i,
    input  logic [LANE_N*DATA_W-1:0]   data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [LANE_N*HEAD_W-1:0]   head_o,
    output logic [LANE_N*DATA_W-1:0]   data_o
);
    localparam int CNT_W = $clog2(AM_PERIOD);
    // {M2,M1,M0} per lane
    localparam logic [3:0][23:0] AM_TAB = {24'h3D79A2, 24'h9B65C5, 24'hE6C4F0, 24'h477690};
    logic                     r_am_q;
    logic                     r_valid;
    logic [CNT_W-1:0]         r_cnt;
    logic [LANE_N*HEAD_W-1:0] r_head;
    logic [LANE_N*DATA_W-1:0] r_data;
    logic [LANE_N-1:0][7:0]   w_bip3;
    logic [LANE_N*DATA_W-1:0] w_am_data;
    logic                     w_wrap;
    assign ready_o = ~r_am_q;
    assign valid_o = r_valid;
    assign head_o  = r_head;
    assign data_o  = r_data;
    assign w_wrap  = r_cnt == CNT_W'(AM_PERIOD - 1);
`ifdef PCS_AM_BIP_EN
    // data bit n lands in BIP bit n%8; head[0] in bit3, head[1] in bit4
    function automatic logic [7:0] blk_par(input logic [1:0] h, input logic [63:0] d);
        logic [7:0] p;
        p = {3'b000, h, 3'b000};
        for (int k = 0; k < 8; k++) p ^= d[8*k+:8];
        return p;
    endfunction
`endif
    for (genvar i = 0; i < LANE_N; i++) begin : g_lane
        assign w_am_data[i*DATA_W+:DATA_W] = {~w_bip3[i], ~AM_TAB[i], w_bip3[i], AM_TAB[i]};
`ifdef PCS_AM_BIP_EN
        logic [7:0] r_bip;
        assign w_bip3[i] = r_bip;
        always_ff @(posedge clk) begin
            if (!nreset)
                r_bip <= '0;
            else
                r_bip <= r_am_q ? blk_par(2'b01, w_am_data[i*DATA_W+:DATA_W])
                                : r_bip ^ blk_par(head_i[i*HEAD_W+:HEAD_W], data_i[i*DATA_W+:DATA_W]);
        end
`else
        assign w_bip3[i] = 8'h00;
`endif
    end
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_am_q  <= 1'b1;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_head  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= 1'b1;
            r_am_q  <= ~r_am_q & w_wrap;
            r_head  <= r_am_q ? {LANE_N{HEAD_W'(1)}} : head_i;
            r_data  <= r_am_q ? w_am_data : data_i;
            if (!r_am_q) r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pcs_am_insert.sv
// tb_pcs_am_insert: directed bench for pcs_am_insert with 4 lanes and a 4-block marker period.
module tb_pcs_am_insert;
`ifdef PCS_AM_BIP_EN
    localparam bit BIP_EN = 1'b1;
`else
    localparam bit BIP_EN = 1'b0;
`endif
    localparam logic [7:0] AMT [4][3] = '{'{8'h90, 8'h76, 8'h47}, '{8'hF0, 8'hC4, 8'hE6},
                                          '{8'hC5, 8'h65, 8'h9B}, '{8'hA2, 8'h79, 8'h3D}};
    localparam logic [63:0] AM0 [4] = '{64'hFFB8896F00477690, 64'hFF193B0F00E6C4F0,
                                        64'hFF649A3A009B65C5, 64'hFFC2865D003D79A2};
    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic [7:0]   head_i = '0;
    logic [255:0] data_i = '0;
    logic         ready_o, valid_o;
    logic [7:0]   head_o;
    logic [255:0] data_o;
    int           total = 0;
    int           bad = 0;
    int           idx;
    bit           flip = 1'b0;
    logic [7:0]   acc [4];
    logic [63:0]  am2 [4];
    logic [63:0]  am2_ref [4];
    always #5 clk = ~clk;
    pcs_am_insert #(.LANE_N(4), .DATA_W(64), .HEAD_W(2), .AM_PERIOD(4)) dut (
        .clk(clk), .nreset(nreset), .head_i(head_i), .data_i(data_i),
        .ready_o(ready_o), .valid_o(valid_o), .head_o(head_o), .data_o(data_o)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] bd(input int n, input int l);
        logic [63:0] d;
        d = 64'h0123456789ABCDEF ^ ({32'(n * 7 + 1), 32'(l * 13 + n)} << l);
        if (flip && n == 2 && l == 1) d[0] = ~d[0];
        return d;
    endfunction
    function automatic logic [1:0] bh(input int n, input int l);
        return ((n + l) % 3 == 0) ? 2'b01 : 2'b10;
    endfunction
    // block bit k: b[0:1]=head, b[2+n]=data[n]; mapped onto the BIP bit lists
    function automatic logic [7:0] ref_par(input logic [1:0] h, input logic [63:0] d);
        logic [7:0] p;
        p = '0;
        for (int k = 0; k < 66; k++) begin
            if (k < 2) p[k + 3] ^= h[k];
            else p[(k - 2) % 8] ^= d[k - 2];
        end
        return p;
    endfunction
    function automatic logic [63:0] am_word(input int l, input logic [7:0] bip);
        return {~bip, ~AMT[l][2], ~AMT[l][1], ~AMT[l][0], bip, AMT[l][2], AMT[l][1], AMT[l][0]};
    endfunction
    task automatic present();
        for (int l = 0; l < 4; l++) begin
            head_i[l*2+:2]  = bh(idx, l);
            data_i[l*64+:64] = bd(idx, l);
        end
    endtask
    task automatic run(input int ncyc, input int base, input string sc);
        logic rdy;
        logic [63:0] w;
        int n;
        idx = base;
        present();
        for (int l = 0; l < 4; l++) acc[l] = 8'h00;
        @(posedge clk); #1;
        check($sformatf("%s_rst_valid", sc), 64'(valid_o), 64'd0);
        check($sformatf("%s_rst_head", sc), 64'(head_o), 64'd0);
        check($sformatf("%s_rst_data", sc), 64'(|data_o), 64'd0);
        nreset = 1'b1;
        for (int e = 0; e < ncyc; e++) begin
            check($sformatf("%s_ready_c%0d", sc, e), 64'(ready_o), 64'(e % 5 != 0));
            rdy = ready_o;
            @(posedge clk); #1;
            if (rdy) idx++;
            present();
            check($sformatf("%s_valid_c%0d", sc, e), 64'(valid_o), 64'd1);
            for (int l = 0; l < 4; l++) begin
                if (e % 5 == 0) begin
                    w = am_word(l, BIP_EN ? acc[l] : 8'h00);
                    check($sformatf("%s_am_c%0d_l%0d", sc, e, l), data_o[l*64+:64], w);
                    check($sformatf("%s_amhead_c%0d_l%0d", sc, e, l), 64'(head_o[l*2+:2]), 64'd1);
                    if (e == 0) check($sformatf("%s_am0const_l%0d", sc, l), data_o[l*64+:64], AM0[l]);
                    if (e == 5) am2[l] = data_o[l*64+:64];
                    acc[l] = ref_par(2'b01, w);
                end else begin
                    n = base + e - e / 5 - 1;
                    check($sformatf("%s_d%0d_c%0d_l%0d", sc, n, e, l), data_o[l*64+:64], bd(n, l));
                    check($sformatf("%s_dhead%0d_l%0d", sc, n, l), 64'(head_o[l*2+:2]), 64'(bh(n, l)));
                    acc[l] ^= ref_par(bh(n, l), bd(n, l));
                end
            end
        end
    endtask
    initial begin
        run(20, 0, "flow");
        for (int l = 0; l < 4; l++) am2_ref[l] = am2[l];
        nreset = 1'b0;
        flip = 1'b1;
        run(10, 0, "flip");
        for (int l = 0; l < 4; l++)
            check($sformatf("flipdiff_l%0d", l), am2[l] ^ am2_ref[l],
                  (BIP_EN && l == 1) ? 64'h0100000001000000 : 64'h0);
        flip = 1'b0;
        nreset = 1'b0;
        run(4, 0, "pre_rst");
        nreset = 1'b0;
        run(8, 3, "post_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
